// File: rtl/ddr_capture_gearbox_if.sv
// ---------------------------------------------------------------------------
// ddr_capture_gearbox_if
//
// Purpose: groups the data-path and control signals of ddr_capture_gearbox.
//
// Signals:
//   en          capture enable (sampled at posedge)
//   slip        one-pair word-boundary slip request (sampled at posedge)
//   din         WIDTH-bit DDR input data
//   pair_rise   realigned rising-edge sample
//   pair_fall   realigned falling-edge sample
//   pair_valid  pair_rise/pair_fall hold a new pair this cycle
//   dout        packed word, 2*WIDTH*RATIO bits
//   dout_valid  one-cycle strobe, dout is new
//   slip_busy   slip in progress, further slip requests are dropped
//
// Strobe semantics: there is no back-pressure. pair_valid and dout_valid
// qualify their data for exactly the cycle they are high; the consumer must
// take the data in that cycle. dout holds its value between strobes.
//
// Modports:
//   master  drives en/slip/din and observes the outputs (source side)
//   slave   the capture block itself
// ---------------------------------------------------------------------------
interface ddr_capture_gearbox_if #(
    parameter int WIDTH = 4,
    parameter int RATIO = 4
);
    logic                       en;
    logic                       slip;
    logic [WIDTH-1:0]           din;
    logic [WIDTH-1:0]           pair_rise;
    logic [WIDTH-1:0]           pair_fall;
    logic                       pair_valid;
    logic [2*WIDTH*RATIO-1:0]   dout;
    logic                       dout_valid;
    logic                       slip_busy;

    modport master (
        output en, slip, din,
        input  pair_rise, pair_fall, pair_valid, dout, dout_valid, slip_busy
    );

    modport slave (
        input  en, slip, din,
        output pair_rise, pair_fall, pair_valid, dout, dout_valid, slip_busy
    );
endinterface

// File: rtl/ddr_capture_gearbox.sv
// ---------------------------------------------------------------------------
// ddr_capture_gearbox
//
// Purpose: captures a WIDTH-bit bus on both clock edges, realigns each
// rise/fall pair onto the rising edge and packs RATIO consecutive pairs into
// one 2*WIDTH*RATIO-bit word. A slip request drops exactly one pair so the
// word boundary moves one pair later.
//
// Ports:
//   clk           clock, data sampled on both edges
//   rst_n         synchronous active-low reset
//   bus           ddr_capture_gearbox_if.slave (en, slip, din in;
//                 pair_*, dout, dout_valid, slip_busy out)
//   o_slip_state  current slip FSM state (0 IDLE, 1 ARMED, 2 GUARD)
//
// Word layout: slot i lives in dout[2*WIDTH*i +: 2*WIDTH], rise sample in
// the lower WIDTH bits, fall sample in the upper WIDTH bits.
// ---------------------------------------------------------------------------
module ddr_capture_gearbox #(
    parameter int WIDTH = 4,
    parameter int RATIO = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ddr_capture_gearbox_if.slave bus,
    output logic [1:0]           o_slip_state
);

    localparam int PAIR_W = 2 * WIDTH;
    localparam int WORD_W = PAIR_W * RATIO;
    localparam int CNT_W  = (RATIO > 1) ? $clog2(RATIO) : 1;

    // GUARD stays busy for two full cycles after the discard cycle, so the
    // exit happens on the third posedge spent in GUARD.
    localparam logic [1:0] GUARD_LAST = 2'd2;

    typedef enum logic [1:0] {
        SLIP_IDLE  = 2'd0,
        SLIP_ARMED = 2'd1,
        SLIP_GUARD = 2'd2
    } slip_state_t;

    // Capture stage
    logic [WIDTH-1:0]  r_q;
    logic              r_en_q;
    logic [WIDTH-1:0]  r_f_q;

    // Realign stage
    logic [WIDTH-1:0]  r_pair_rise;
    logic [WIDTH-1:0]  r_pair_fall;
    logic              r_pair_valid;

    // Gearbox
    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_acc;
    logic [WORD_W-1:0] r_dout;
    logic              r_dout_valid;

    // Slip FSM
    slip_state_t       r_state;
    slip_state_t       w_state_nxt;
    logic [1:0]        r_guard_cnt;
    logic [1:0]        w_guard_nxt;

    logic              w_take;
    logic              w_last;
    logic [WORD_W-1:0] w_word;

    // -----------------------------------------------------------------------
    // Capture: rising sample gated by en, falling sample gated by the
    // registered enable so both halves of a pair belong to the same cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q    <= '0;
            r_en_q <= 1'b0;
        end else begin
            if (bus.en) begin
                r_q <= bus.din;
            end
            r_en_q <= bus.en;
        end
    end

    always_ff @(negedge clk) begin
        if (!rst_n) begin
            r_f_q <= '0;
        end else if (r_en_q) begin
            r_f_q <= bus.din;
        end
    end

    // -----------------------------------------------------------------------
    // Realign: r_q was taken at the previous posedge and r_f_q at the negedge
    // in between, so together they form one pair on the rising edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pair_rise  <= '0;
            r_pair_fall  <= '0;
            r_pair_valid <= 1'b0;
        end else begin
            r_pair_rise  <= r_q;
            r_pair_fall  <= r_f_q;
            r_pair_valid <= r_en_q;
        end
    end

    // -----------------------------------------------------------------------
    // Gearbox: a valid pair is dropped while the slip FSM is ARMED; that
    // leaves cnt untouched, which is what shifts the boundary by one pair.
    // -----------------------------------------------------------------------
    assign w_take = r_pair_valid && (r_state != SLIP_ARMED);
    assign w_last = (r_cnt == CNT_W'(RATIO - 1));

    // Accumulator with the current pair merged into slot cnt.
    always_comb begin
        w_word = r_acc;
        for (int i = 0; i < RATIO; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_word[i*PAIR_W +: PAIR_W] = {r_pair_fall, r_pair_rise};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_acc        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= w_take && w_last;
            if (w_take) begin
                r_acc <= w_word;
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_dout <= w_word;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Slip FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= SLIP_IDLE;
            r_guard_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_guard_cnt <= w_guard_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_guard_nxt = r_guard_cnt;
        case (r_state)
            SLIP_IDLE: begin
                if (bus.slip) begin
                    w_state_nxt = SLIP_ARMED;
                end
            end
            SLIP_ARMED: begin
                // Waits indefinitely (e.g. en low) for the pair to discard.
                if (r_pair_valid) begin
                    w_state_nxt = SLIP_GUARD;
                    w_guard_nxt = '0;
                end
            end
            SLIP_GUARD: begin
                if (r_guard_cnt == GUARD_LAST) begin
                    w_state_nxt = SLIP_IDLE;
                    w_guard_nxt = '0;
                end else begin
                    w_guard_nxt = r_guard_cnt + 2'd1;
                end
            end
            default: begin
                w_state_nxt = SLIP_IDLE;
                w_guard_nxt = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs: all driven from registers, no path from din.
    // -----------------------------------------------------------------------
    assign bus.pair_rise  = r_pair_rise;
    assign bus.pair_fall  = r_pair_fall;
    assign bus.pair_valid = r_pair_valid;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.slip_busy  = (r_state != SLIP_IDLE);
    assign o_slip_state   = r_state;

endmodule

// File: tb/tb_ddr_capture_gearbox.sv
// ---------------------------------------------------------------------------
// tb_ddr_capture_gearbox
//
// Two instances share clock, reset, en and slip:
//   dut_a  WIDTH=1, RATIO=4
//   dut_b  WIDTH=2, RATIO=2
// Each call of tick() presents one DDR pair: the rise value is set before
// posedge P_c, the fall value right after it. Outputs are sampled 2 ns after
// P_c. Pair c therefore appears on pair_* after tick c+1, and a word whose
// last pair is c strobes dout_valid after tick c+2.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ddr_capture_gearbox;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ddr_capture_gearbox_if #(.WIDTH(1), .RATIO(4)) ifa ();
    ddr_capture_gearbox_if #(.WIDTH(2), .RATIO(2)) ifb ();

    logic [1:0] st_a;
    logic [1:0] st_b;

    ddr_capture_gearbox #(.WIDTH(1), .RATIO(4)) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (ifa),
        .o_slip_state (st_a)
    );

    ddr_capture_gearbox #(.WIDTH(2), .RATIO(2)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (ifb),
        .o_slip_state (st_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic tick(input logic rst, input logic e, input logic s,
                        input logic [1:0] r, input logic [1:0] f);
        @(negedge clk);
        #2;
        rst_n    = rst;
        ifa.en   = e;
        ifb.en   = e;
        ifa.slip = s;
        ifb.slip = s;
        ifa.din  = r[0];
        ifb.din  = r;
        @(posedge clk);
        #2;
        ifa.din  = f[0];
        ifb.din  = f;
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        tick(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_dout"},  {24'd0, ifa.dout}, 32'd0);
        check({tag, "_dv"},    {31'd0, ifa.dout_valid}, 32'd0);
        check({tag, "_pv"},    {31'd0, ifa.pair_valid}, 32'd0);
        check({tag, "_pr"},    {31'd0, ifa.pair_rise}, 32'd0);
        check({tag, "_pf"},    {31'd0, ifa.pair_fall}, 32'd0);
        check({tag, "_busy"},  {31'd0, ifa.slip_busy}, 32'd0);
        check({tag, "_state"}, {30'd0, st_a}, 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected end");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        rst_n    = 1'b0;
        ifa.en   = 1'b0;
        ifb.en   = 1'b0;
        ifa.slip = 1'b0;
        ifb.slip = 1'b0;
        ifa.din  = '0;
        ifb.din  = '0;

        // Reset state
        do_reset();
        check_zero_a("rst");
        check("rst_b_dv",   {31'd0, ifb.dout_valid}, 32'd0);
        check("rst_b_dout", {24'd0, ifb.dout}, 32'd0);

        // Test 1: rise=1 fall=0 for 4 pairs -> 8'h55, strobe after tick 5
        for (int c = 0; c < 7; c++) begin
            tick(1'b1, (c < 4), 1'b0, 2'b01, 2'b00);
            check("t1_dv", {31'd0, ifa.dout_valid}, {31'd0, (c == 5)});
            check("t1_pv", {31'd0, ifa.pair_valid}, {31'd0, (c >= 1 && c <= 4)});
            if (c >= 1 && c <= 4) begin
                check("t1_pr", {31'd0, ifa.pair_rise}, 32'd1);
                check("t1_pf", {31'd0, ifa.pair_fall}, 32'd0);
            end
            if (c == 5) check("t1_dout", {24'd0, ifa.dout}, 32'h55);
        end

        // Test 2: rise=0 fall=1 -> 8'hAA
        for (int c = 0; c < 7; c++) begin
            tick(1'b1, (c < 4), 1'b0, 2'b00, 2'b01);
            check("t2_dv", {31'd0, ifa.dout_valid}, {31'd0, (c == 5)});
            check("t2_pv", {31'd0, ifa.pair_valid}, {31'd0, (c >= 1 && c <= 4)});
            if (c >= 1 && c <= 4) begin
                check("t2_pr", {31'd0, ifa.pair_rise}, 32'd0);
                check("t2_pf", {31'd0, ifa.pair_fall}, 32'd1);
            end
            if (c == 5) check("t2_dout", {24'd0, ifa.dout}, 32'hAA);
        end

        // Test 3: dut_b, values 0,1,2,3 repeating -> 8'hE4 every 2 cycles
        for (int c = 0; c < 10; c++) begin
            logic odd;
            odd = (c % 2) == 1;
            tick(1'b1, (c < 8), 1'b0, odd ? 2'd2 : 2'd0, odd ? 2'd3 : 2'd1);
            check("t3_dv", {31'd0, ifb.dout_valid}, {31'd0, (c >= 3 && odd)});
            if (c >= 3 && odd) check("t3_dout", {24'd0, ifb.dout}, 32'hE4);
        end

        // Test 4: slip in continuous stream; second slip while busy ignored
        do_reset();
        for (int c = 0; c < 20; c++) begin
            tick(1'b1, 1'b1, (c == 6 || c == 8), 2'b01, 2'b00);
            check("t4_dv", {31'd0, ifa.dout_valid},
                  {31'd0, (c == 5 || c == 10 || c == 14 || c == 18)});
            check("t4_busy", {31'd0, ifa.slip_busy}, {31'd0, (c >= 6 && c <= 9)});
            if (c == 6) check("t4_armed", {30'd0, st_a}, 32'd1);
            if (c == 7) check("t4_guard", {30'd0, st_a}, 32'd2);
            if (c == 5 || c == 10 || c == 14 || c == 18)
                check("t4_dout", {24'd0, ifa.dout}, 32'h55);
        end

        // Test 5: en low for 3 cycles after 2 pairs
        do_reset();
        for (int c = 0; c < 10; c++) begin
            tick(1'b1, (c < 2 || c == 5 || c == 6), 1'b0, 2'b01, 2'b00);
            check("t5_pv", {31'd0, ifa.pair_valid},
                  {31'd0, (c == 1 || c == 2 || c == 6 || c == 7)});
            check("t5_dv", {31'd0, ifa.dout_valid}, {31'd0, (c == 8)});
            if (c == 8) check("t5_dout", {24'd0, ifa.dout}, 32'h55);
        end

        // Test 6: reset pulse after 3 pairs with a slip pending
        for (int c = 0; c < 11; c++) begin
            tick((c != 3), (c <= 2 || (c >= 4 && c <= 7)), (c == 2), 2'b01, 2'b00);
            if (c == 2) check("t6_busy_pre", {31'd0, ifa.slip_busy}, 32'd1);
            if (c == 3) check_zero_a("t6_rst");
            check("t6_dv", {31'd0, ifa.dout_valid}, {31'd0, (c == 9)});
            if (c == 9) check("t6_dout", {24'd0, ifa.dout}, 32'h55);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
